// File: rtl/lcv_mac_seq_pkg.sv
// Shared types and widths for the lcv_mac_seq packet MAC sequencer.
package lcv_mac_seq_pkg;

   localparam int LCV_MAC_OP_W    = 16;
   localparam int LCV_MAC_ACC_W   = 33;
   localparam int LCV_MAC_EXACT_W = 35;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } lcv_mac_state_e;

endpackage

// File: rtl/lcv_mac_seq_mulacc.sv
// DSP slice model: registered p = a*b + c + d + e, modulo 2^33, no reset on the register.
module LcvMulAcc32Del1 (
   input  logic               clk,
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   input  logic signed [32:0] c,
   input  logic signed [32:0] d,
   input  logic signed [32:0] e,
   output logic signed [32:0] p
);

   logic signed [31:0] prod;
   logic signed [32:0] p_q;

   assign prod = 32'(a) * 32'(b);

   always_ff @(posedge clk) begin
      p_q <= 33'(prod) + c + d + e;
   end

   assign p = p_q;

endmodule

// File: rtl/lcv_mac_seq.sv
// Packet-framed signed MAC sequencer wrapped around one LcvMulAcc32Del1 slice,
// with a 35-bit shadow sum for sticky overflow and a saturating term counter.
module lcv_mac_seq
   import lcv_mac_seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            inp_valid,
   output logic                            inp_ready,
   input  logic signed [LCV_MAC_OP_W-1:0]  inp_a,
   input  logic signed [LCV_MAC_OP_W-1:0]  inp_b,
   input  logic                            inp_last,
   input  logic signed [LCV_MAC_ACC_W-1:0] inp_bias,
   output logic                            outp_valid,
   input  logic                            outp_ready,
   output logic signed [LCV_MAC_ACC_W-1:0] outp_data,
   output logic                            outp_ovf,
   output logic [CNT_W-1:0]                outp_count
);

   // Handshakes: a beat moves on a port when valid && ready at the rising edge;
   // valid never depends on ready, and a presented result holds until taken.

   lcv_mac_state_e state_q, state_d;
   logic first_q, first_d;
   logic ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic xfer;
   logic signed [LCV_MAC_OP_W-1:0]    slc_a, slc_b;
   logic signed [LCV_MAC_ACC_W-1:0]   slc_c, slc_d, acc;
   logic signed [31:0]                prod;
   logic signed [LCV_MAC_EXACT_W-1:0] exact;
   logic step_ovf;

   assign inp_ready = (state_q == ACCUM);
   assign xfer      = inp_valid && inp_ready;

   // Without a transfer the slice is fed its own output, so the register holds.
   always_comb begin
      slc_a = '0;
      slc_b = '0;
      slc_c = acc;
      slc_d = '0;
      if (xfer) begin
         slc_a = inp_a;
         slc_b = inp_b;
         slc_c = first_q ? '0 : acc;
         slc_d = first_q ? inp_bias : '0;
      end
   end

   LcvMulAcc32Del1 u_slice (
      .clk (clk),
      .a   (slc_a),
      .b   (slc_b),
      .c   (slc_c),
      .d   (slc_d),
      .e   ('0),
      .p   (acc)
   );

   assign prod     = 32'(slc_a) * 32'(slc_b);
   assign exact    = 35'(prod) + 35'(slc_c) + 35'(slc_d);
   assign step_ovf = (exact != {{2{exact[32]}}, exact[32:0]});

   always_comb begin
      state_d = state_q;
      first_d = first_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      case (state_q)
         ACCUM: begin
            if (xfer) begin
               first_d = 1'b0;
               ovf_d   = first_q ? step_ovf : (ovf_q | step_ovf);
               if (first_q) begin
                  cnt_d = CNT_W'(1);
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (inp_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (outp_ready) begin
               state_d = ACCUM;
               first_d = 1'b1;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ACCUM;
         first_q <= 1'b1;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign outp_valid = (state_q == DONE);
   assign outp_data  = outp_valid ? acc : '0;
   assign outp_ovf   = outp_valid ? ovf_q : 1'b0;
   assign outp_count = outp_valid ? cnt_q : '0;

endmodule

// File: tb/tb_lcv_mac_seq.sv
// Randomised and directed bench for lcv_mac_seq with a queue-based scoreboard.
module tb_lcv_mac_seq;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int EXP_W   = 33 + 1 + CNT_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic               inp_valid = 1'b0;
   logic               inp_ready;
   logic signed [15:0] inp_a = '0;
   logic signed [15:0] inp_b = '0;
   logic               inp_last = 1'b0;
   logic signed [32:0] inp_bias = '0;
   logic               outp_valid;
   logic               outp_ready = 1'b0;
   logic signed [32:0] outp_data;
   logic               outp_ovf;
   logic [CNT_W-1:0]   outp_count;

   lcv_mac_seq #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .inp_valid  (inp_valid),
      .inp_ready  (inp_ready),
      .inp_a      (inp_a),
      .inp_b      (inp_b),
      .inp_last   (inp_last),
      .inp_bias   (inp_bias),
      .outp_valid (outp_valid),
      .outp_ready (outp_ready),
      .outp_data  (outp_data),
      .outp_ovf   (outp_ovf),
      .outp_count (outp_count)
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model (packet arithmetic) ----------------
   longint m_acc   = 0;
   bit     m_first = 1'b1;
   bit     m_ovf   = 1'b0;
   int     m_cnt   = 0;

   function automatic longint wrap33(input longint s);
      logic [63:0]        u;
      logic signed [32:0] t;
      u = s;
      t = u[32:0];
      return longint'(t);
   endfunction

   task automatic model_term(input logic signed [15:0] a, input logic signed [15:0] b,
                             input logic signed [32:0] bias, input bit last);
      longint s;
      bit     step;
      logic [32:0]      d33;
      logic [CNT_W-1:0] c8;
      s    = longint'(a) * longint'(b) + (m_first ? longint'(bias) : m_acc);
      step = (s > 64'sd4294967295) || (s < -64'sd4294967296);
      m_ovf = m_first ? step : (m_ovf | step);
      m_cnt = m_first ? 1 : ((m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1);
      m_acc = wrap33(s);
      m_first = 1'b0;
      if (last) begin
         d33 = 33'(m_acc);
         c8  = CNT_W'(m_cnt);
         exp_q.push_back({d33, m_ovf, c8});
         m_first = 1'b1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_term(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic signed [32:0] bias, input bit last);
      int waits;
      logic [63:0] r;
      waits     = 0;
      inp_valid = 1'b1;
      inp_a     = a;
      inp_b     = b;
      inp_bias  = bias;
      inp_last  = last;
      @(negedge clk);
      while (!inp_ready) begin
         waits++;
         if (waits > 300) begin
            $display("FAIL in_handshake_timeout: inp_ready stayed 0 for %0d cycles, required 1", waits);
            $fatal(1);
         end
         @(negedge clk);
      end
      model_term(a, b, bias, last);
      @(posedge clk);
      #1;
      r         = {$urandom, $urandom};
      inp_valid = 1'b0;
      inp_a     = 16'($urandom);
      inp_b     = 16'($urandom);
      inp_last  = 1'($urandom);
      inp_bias  = r[32:0];
   endtask

   task automatic wait_drain();
      int waits;
      waits = 0;
      while (exp_q.size() != 0) begin
         waits++;
         if (waits > 500) begin
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            $fatal(1);
         end
         idle(1);
      end
   endtask

   function automatic logic signed [15:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return -16'sd32768;
         1:       return 16'sd32767;
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- output ready driver ----------------
   bit force_rdy = 1'b0;
   bit force_val = 1'b0;
   always @(posedge clk) begin
      #1;
      outp_ready = force_rdy ? force_val : ($urandom_range(0, 3) != 0);
   end

   // ---------------- monitor ----------------
   bit                 pend_last = 1'b0;
   bit                 exp_rdy_next = 1'b0;
   bit                 hold_prev = 1'b0;
   logic signed [32:0] prev_data;
   logic               prev_ovf;
   logic [CNT_W-1:0]   prev_cnt;

   task automatic check(input bit ok, input string name, input string detail);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!rst) begin
         check(!outp_valid && outp_data == '0 && !outp_ovf && outp_count == '0 && inp_ready,
               "reset_outputs",
               $sformatf("valid=%0b data=%0d ovf=%0b count=%0d inp_ready=%0b, required 0 0 0 0 1",
                         outp_valid, outp_data, outp_ovf, outp_count, inp_ready));
         pend_last    = 1'b0;
         exp_rdy_next = 1'b0;
         hold_prev    = 1'b0;
      end else begin
         check(inp_ready == !outp_valid, "ready_vs_valid",
               $sformatf("inp_ready=%0b outp_valid=%0b, required inp_ready=!outp_valid",
                         inp_ready, outp_valid));
         if (pend_last) begin
            check(outp_valid, "result_latency",
                  $sformatf("outp_valid=%0b one cycle after last transfer, required 1", outp_valid));
            pend_last = 1'b0;
         end
         if (exp_rdy_next) begin
            check(inp_ready, "ready_after_handshake",
                  $sformatf("inp_ready=%0b after output handshake, required 1", inp_ready));
            exp_rdy_next = 1'b0;
         end
         if (!outp_valid) begin
            if (outp_data != '0 || outp_ovf || outp_count != '0)
               check(1'b0, "idle_outputs_zero",
                     $sformatf("data=%0d ovf=%0b count=%0d while not valid, required 0",
                               outp_data, outp_ovf, outp_count));
         end
         if (hold_prev) begin
            check(outp_valid && outp_data == prev_data && outp_ovf == prev_ovf && outp_count == prev_cnt,
                  "hold_stable",
                  $sformatf("valid=%0b data=%0d ovf=%0b count=%0d, required 1 %0d %0d %0d",
                            outp_valid, outp_data, outp_ovf, outp_count, prev_data, prev_ovf, prev_cnt));
         end
         hold_prev = 1'b0;
         if (outp_valid && !outp_ready) begin
            hold_prev = 1'b1;
            prev_data = outp_data;
            prev_ovf  = outp_ovf;
            prev_cnt  = outp_count;
         end
         if (outp_valid && outp_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_result",
                     $sformatf("data=%0d with empty expected queue, required no result", outp_data));
            end else begin
               e = exp_q.pop_front();
               check(outp_data == e[EXP_W-1 -: 33] && outp_ovf == e[CNT_W] && outp_count == e[CNT_W-1:0],
                     "result",
                     $sformatf("data=%0d ovf=%0b count=%0d, required data=%0d ovf=%0b count=%0d",
                               outp_data, outp_ovf, outp_count, $signed(e[EXP_W-1 -: 33]),
                               e[CNT_W], e[CNT_W-1:0]));
            end
            exp_rdy_next = 1'b1;
         end
         if (inp_valid && inp_ready && inp_last) pend_last = 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int len;
      int waits;
      idle(3);
      rst = 1'b1;
      idle(2);

      // Back-to-back packet: 10 + 12 - 30 - 56 = -64
      send_term(16'sd3, 16'sd4, 33'sd10, 1'b0);
      send_term(-16'sd5, 16'sd6, 33'sd0, 1'b0);
      send_term(16'sd7, -16'sd8, 33'sd0, 1'b1);
      wait_drain();

      // Single-term packet: 2^30
      send_term(-16'sd32768, -16'sd32768, 33'sd0, 1'b1);
      wait_drain();

      // Overflow on the fourth term; result wraps to -3*2^30
      for (int i = 0; i < 5; i++) send_term(-16'sd32768, -16'sd32768, 33'sd0, i == 4);
      wait_drain();

      // Back-pressure: hold the result for 5 cycles before taking it
      force_rdy = 1'b1;
      force_val = 1'b0;
      send_term(16'sd3, 16'sd4, 33'sd10, 1'b0);
      send_term(-16'sd5, 16'sd6, 33'sd0, 1'b0);
      send_term(16'sd7, -16'sd8, 33'sd0, 1'b1);
      waits = 0;
      while (!outp_valid) begin
         waits++;
         if (waits > 50) begin
            $display("FAIL outp_valid_timeout: outp_valid stayed 0, required 1");
            $fatal(1);
         end
         idle(1);
      end
      idle(5);
      force_val = 1'b1;
      idle(2);
      force_rdy = 1'b0;
      wait_drain();

      // Input bubbles between every term
      send_term(16'sd3, 16'sd4, 33'sd10, 1'b0);
      idle(3);
      send_term(-16'sd5, 16'sd6, 33'sd0, 1'b0);
      idle(3);
      send_term(16'sd7, -16'sd8, 33'sd0, 1'b1);
      wait_drain();

      // Count saturation on a long packet
      for (int i = 0; i < CNT_MAX + 5; i++) send_term(16'sd1, 16'sd1, 33'sd0, i == CNT_MAX + 4);
      wait_drain();

      // Randomised packets with random bubbles and random output back-pressure
      for (int p = 0; p < 30; p++) begin
         logic [63:0] r;
         r   = {$urandom, $urandom};
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            send_term(rand_op(), rand_op(), (i == 0) ? r[32:0] : 33'($urandom), i == len - 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         end
      end
      wait_drain();

      // Reset mid-packet discards the partial sum
      send_term(16'sd100, 16'sd100, 33'sd5, 1'b0);
      send_term(16'sd200, 16'sd7, 33'sd0, 1'b0);
      rst = 1'b0;
      idle(3);
      rst     = 1'b1;
      m_first = 1'b1;
      idle(1);
      send_term(16'sd1, 16'sd1, 33'sd0, 1'b1);
      wait_drain();
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lcv_mac_seq.md
# lcv_mac_seq

Streaming signed multiply-accumulate sequencer that sits directly upstream of, and around, one `LcvMulAcc32Del1` DSP slice. It accepts a packet of signed 16x16 operand pairs over a valid/ready stream and feeds them to the slice one per cycle, using the slice's registered output as the running accumulator. At the end of the packet it presents one 33-bit result, a sticky overflow flag and a term count on a valid/ready output. It is used for dot products and FIR taps where an `LcvMulAcc32Del1` alone has no packet framing or back-pressure.

## Interface
- `CNT_W`, default 8: width of the term counter and `outp_count`.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (`rst == 0` resets).
- `inp_valid` input 1: operand pair valid.
- `inp_ready` output 1: block accepts a pair this cycle.
- `inp_a` input 16 signed: multiplicand.
- `inp_b` input 16 signed: multiplier.
- `inp_last` input 1: pair is the final term of the packet.
- `inp_bias` input 33 signed: packet bias; sampled only with the first term.
- `outp_valid` output 1: result valid.
- `outp_ready` input 1: consumer takes the result.
- `outp_data` output 33 signed: accumulated sum, modulo 2^33.
- `outp_ovf` output 1: at least one accumulation step left the signed 33-bit range.
- `outp_count` output CNT_W: terms in the packet, saturating at 2^CNT_W-1.

## Operation
- States: `ACCUM` and `DONE`. Reset enters `ACCUM` with `first = 1`, count 0 and ovf 0.
- A transfer happens when `inp_valid && inp_ready`. `inp_ready = (state == ACCUM)`.
- Drive the slice as follows:
  - When a transfer happens: `a = inp_a`, `b = inp_b`, `c = first ? 0 : acc`, `d = first ? inp_bias : 0`, `e = 0`.
  - Otherwise: `a = b = 0`, `c = acc`, `d = e = 0`. This holds the register value.
  - `acc` is the slice output.
- The slice register has no reset. Correctness after reset relies only on `first` forcing `c = 0`.
- Overflow detection:
  - Form the exact 35-bit sum `inp_a*inp_b + c + d` in the wrapper, in parallel with the slice.
  - If the sum is not representable in 33 signed bits, set sticky ovf.
  - The first term loads ovf from this check instead of ORing into it.
- Each transfer increments count, saturating. The first term loads count = 1. Each transfer clears `first`.
- A transfer with `inp_last` moves the state to `DONE`.
- In `DONE`, `outp_valid = 1`. When `outp_valid && outp_ready`, return to `ACCUM` with `first = 1`.
- A single-term packet (first and last on the same transfer) is legal.
- While `outp_valid == 0`: `outp_data`, `outp_ovf` and `outp_count` drive 0.
- While `outp_valid == 1`, all outputs are stable until the handshake.

## Timing
- Throughput: one term per cycle while `inp_valid` stays high. There is one forced bubble per packet, because `inp_ready` is 0 in `DONE`.
- Latency: `outp_valid` rises the cycle after the `inp_last` transfer, and the result is valid in that same cycle.
- After the output handshake, `inp_ready` is 1 in the next cycle.
- Gaps in `inp_valid` mid-packet leave the accumulator, count and ovf unchanged.
- Reset values:
  - `inp_ready` = 1, `outp_valid` = 0.
  - `outp_data`, `outp_ovf`, `outp_count` = 0.
- Reset mid-packet discards the partial sum. The first transfer after reset release starts a new packet.
- `inp_bias` on non-first transfers and `inp_a`/`inp_b` without a transfer have no effect.

## Structure
- Package `lcv_mac_seq_pkg`:
  - State enum `{ACCUM, DONE}`.
  - `LCV_MAC_OP_W = 16`, `LCV_MAC_ACC_W = 33`, `LCV_MAC_EXACT_W = 35`.
- One sub-module: an unmodified instance of `LcvMulAcc32Del1`.
- All control, the 35-bit overflow shadow, the counter and output muxing live in `lcv_mac_seq`.

## Test plan
- Single packet with back-to-back transfers:
  - Stimulus: after reset, pairs (3,4), (-5,6), (7,-8, last), bias 10.
  - Expect `outp_data = -64`, count 3, ovf 0, `outp_valid` high one cycle after the last transfer.
- Single-term packet:
  - Stimulus: (-32768,-32768, last), bias 0.
  - Expect `outp_data = 1073741824`, count 1, ovf 0.
- Overflow:
  - Stimulus: five terms (-32768,-32768), bias 0.
  - Expect ovf 1 (first set at term 4), `outp_data = -3221225472`, count 5.
- Back-pressure:
  - Stimulus: hold `outp_ready = 0` for 5 cycles, then raise it.
  - Expect `outp_valid`, data and count stable and `inp_ready = 0` throughout, then `inp_ready = 1` the cycle after the handshake.
- Input bubbles:
  - Stimulus: the packet from the first scenario with 3 idle cycles between every term.
  - Expect the identical result, -64, count 3.
- Reset mid-packet:
  - Stimulus: assert `rst` low after 2 terms, release, then send (1,1, last), bias 0.
  - Expect all outputs 0 during reset, then `outp_data = 1`, count 1, ovf 0.
